// File: rtl/arp_table_if.sv
// Query, learn, flush and statistics signals of the ARP resolution table.
// The classifier/parser side uses the master modport; the table uses slave.
interface arp_table_if #(
   parameter int IP_W  = 32,
   parameter int MAC_W = 48,
   parameter int CNT_W = 32
);
   logic             query_req_valid_i;
   logic             query_req_ready_o;
   logic [IP_W-1:0]  query_ip_i;
   logic             query_resp_valid_o;
   logic             query_resp_ready_i;
   logic [MAC_W-1:0] query_mac_o;
   logic             query_err_o;
   logic             upd_valid_i;
   logic             upd_ready_o;
   logic [IP_W-1:0]  upd_ip_i;
   logic [MAC_W-1:0] upd_mac_i;
   logic             flush_i;
   logic [CNT_W-1:0] hit_cnt_o;
   logic [CNT_W-1:0] miss_cnt_o;

   modport master (
      output query_req_valid_i, query_ip_i, query_resp_ready_i,
             upd_valid_i, upd_ip_i, upd_mac_i, flush_i,
      input  query_req_ready_o, query_resp_valid_o, query_mac_o, query_err_o,
             upd_ready_o, hit_cnt_o, miss_cnt_o
   );

   modport slave (
      input  query_req_valid_i, query_ip_i, query_resp_ready_i,
             upd_valid_i, upd_ip_i, upd_mac_i, flush_i,
      output query_req_ready_o, query_resp_valid_o, query_mac_o, query_err_o,
             upd_ready_o, hit_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/arp_table.sv
// Fully associative IPv4-to-MAC table: registered 1-cycle lookup, learn port with
// fill-then-round-robin replacement, flush, and saturating hit/miss counters.
module arp_table #(
   parameter int ENTRIES = 16,
   parameter int IP_W    = 32,
   parameter int MAC_W   = 48,
   parameter int CNT_W   = 32
) (
   input logic       clk,
   input logic       rst,
   arp_table_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   typedef logic [IDX_W-1:0] idx_t;

   // Table storage
   logic [ENTRIES-1:0] valid_q;
   logic [IP_W-1:0]    ip_q  [ENTRIES];
   logic [MAC_W-1:0]   mac_q [ENTRIES];
   idx_t               rr_q;

   // Response and statistics registers
   logic               resp_valid_q;
   logic [MAC_W-1:0]   resp_mac_q;
   logic               resp_err_q;
   logic [CNT_W-1:0]   hit_cnt_q;
   logic [CNT_W-1:0]   miss_cnt_q;

   logic               req_ready;
   logic               query_accept;
   logic               upd_write;
   logic               q_hit;
   logic [MAC_W-1:0]   q_mac;
   logic               u_match;
   idx_t               u_match_idx;
   logic               u_free;
   idx_t               u_free_idx;
   idx_t               wr_idx;

   assign req_ready    = !resp_valid_q || bus.query_resp_ready_i;
   assign query_accept = bus.query_req_valid_i && req_ready;
   assign upd_write    = bus.upd_valid_i && !bus.flush_i && (bus.upd_ip_i != '0);

   assign bus.query_req_ready_o  = req_ready;
   assign bus.upd_ready_o        = !bus.flush_i;
   assign bus.query_resp_valid_o = resp_valid_q;
   assign bus.query_mac_o        = resp_mac_q;
   assign bus.query_err_o        = resp_err_q;
   assign bus.hit_cnt_o          = hit_cnt_q;
   assign bus.miss_cnt_o         = miss_cnt_q;

   // Scanning from the top down lets the lowest-index match win.
   always_comb begin : query_lookup
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      q_hit = 1'b0;
      q_mac = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (ip_q[i] == bus.query_ip_i)) begin
            q_hit = 1'b1;
            q_mac = mac_q[i];
         end
      end
      if (bus.query_ip_i == '0) begin
         q_hit = 1'b0;
         q_mac = '0;
      end
   end

   always_comb begin : update_slot
      u_match     = 1'b0;
      u_match_idx = '0;
      u_free      = 1'b0;
      u_free_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && (ip_q[i] == bus.upd_ip_i)) begin
            u_match     = 1'b1;
            u_match_idx = idx_t'(i);
         end
         if (!valid_q[i]) begin
            u_free     = 1'b1;
            u_free_idx = idx_t'(i);
         end
      end
      if (u_match)     wr_idx = u_match_idx;
      else if (u_free) wr_idx = u_free_idx;
      else             wr_idx = rr_q;
   end

   // Flush wins over a learn in the same cycle; the learn is stalled by upd_ready_o.
   always_ff @(posedge clk or posedge rst) begin : table_state
      // NOTE: sequential state is assigned with non-blocking (<=) only.
      if (rst) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else if (bus.flush_i) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else if (upd_write) begin
         valid_q[wr_idx] <= 1'b1;
         if (!u_match && !u_free) rr_q <= rr_q + idx_t'(1);
      end
   end

   // NOTE: the key/MAC arrays are not reset; valid_q qualifies every read of them.
   always_ff @(posedge clk) begin : table_data
      if (upd_write) begin
         ip_q[wr_idx]  <= bus.upd_ip_i;
         mac_q[wr_idx] <= bus.upd_mac_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin : response
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_mac_q   <= '0;
         resp_err_q   <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else if (query_accept) begin
         resp_valid_q <= 1'b1;
         resp_mac_q   <= q_mac;
         resp_err_q   <= !q_hit;
         if (q_hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
         end
      end else if (bus.query_resp_ready_i) begin
         resp_valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_arp_table.sv
// Self-checking bench for arp_table: directed scenarios plus a randomized run,
// all checked against an array-based table model kept in the bench.
module tb_arp_table;
   localparam int N  = 16;
   localparam int IW = 32;
   localparam int MW = 48;
   localparam int CW = 6;   // narrow counters so saturation is reached in the random run
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   arp_table_if #(.IP_W(IW), .MAC_W(MW), .CNT_W(CW)) bus ();
   arp_table #(.ENTRIES(N), .IP_W(IW), .MAC_W(MW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: table contents, replacement pointer, pending response, counters
   bit            m_valid [N];
   logic [IW-1:0] m_ip    [N];
   logic [MW-1:0] m_mac   [N];
   int            m_rr;
   bit            m_rv;
   logic [MW-1:0] m_rmac;
   bit            m_rerr;
   int            m_hits, m_misses;
   logic          obs_req_ready, obs_upd_ready;

   function automatic logic [MW-1:0] mac_of(input logic [IW-1:0] ip);
      return {16'h0200, ip};
   endfunction

   function automatic bit m_lookup(input logic [IW-1:0] ip, output logic [MW-1:0] mac);
      mac = '0;
      if (ip == 0) return 1'b0;
      for (int i = 0; i < N; i++)
         if (m_valid[i] && m_ip[i] == ip) begin
            mac = m_mac[i];
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic m_learn(input logic [IW-1:0] ip, input logic [MW-1:0] mac);
      int slot;
      slot = -1;
      if (ip == 0) return;
      for (int i = 0; i < N && slot < 0; i++) if (m_valid[i] && m_ip[i] == ip) slot = i;
      for (int i = 0; i < N && slot < 0; i++) if (!m_valid[i]) slot = i;
      if (slot < 0) begin
         slot = m_rr;
         m_rr = (m_rr + 1) % N;
      end
      m_valid[slot] = 1'b1;
      m_ip[slot]    = ip;
      m_mac[slot]   = mac;
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_rr = 0; m_rv = 0; m_rmac = '0; m_rerr = 0; m_hits = 0; m_misses = 0;
   endtask

   // Drives one cycle of stimulus (starting 1 time unit after a rising edge),
   // records the combinational readies, advances the model, and returns 1 unit
   // after the next rising edge.
   task automatic step(input bit qv, input logic [IW-1:0] qip, input bit uv,
                       input logic [IW-1:0] uip, input logic [MW-1:0] umac,
                       input bit fl, input bit rdy);
      logic [MW-1:0] mac;
      bit            hit;
      bus.query_req_valid_i  = qv;
      bus.query_ip_i         = qip;
      bus.upd_valid_i        = uv;
      bus.upd_ip_i           = uip;
      bus.upd_mac_i          = umac;
      bus.flush_i            = fl;
      bus.query_resp_ready_i = rdy;
      #1;
      obs_req_ready = bus.query_req_ready_o;
      obs_upd_ready = bus.upd_ready_o;
      if (qv && (!m_rv || rdy)) begin
         hit    = m_lookup(qip, mac);
         m_rv   = 1'b1;
         m_rmac = mac;
         m_rerr = !hit;
         if (hit) begin if (m_hits < CMAX) m_hits++; end
         else     begin if (m_misses < CMAX) m_misses++; end
      end else if (rdy) begin
         m_rv = 1'b0;
      end
      if (fl) begin
         for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
         m_rr = 0;
      end else if (uv) begin
         m_learn(uip, umac);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic learn(input logic [IW-1:0] ip, input logic [MW-1:0] mac);
      step(1'b0, '0, 1'b1, ip, mac, 1'b0, 1'b1);
   endtask

   task automatic query(input logic [IW-1:0] ip);
      step(1'b1, ip, 1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      bus.query_req_valid_i = 0; bus.query_ip_i = '0; bus.query_resp_ready_i = 0;
      bus.upd_valid_i = 0; bus.upd_ip_i = '0; bus.upd_mac_i = '0; bus.flush_i = 0;
      rst = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.query_resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.query_resp_valid_o); end
      checks++; if (bus.query_mac_o !== '0) begin errors++; $display("FAIL reset_mac: got %h expected 0", bus.query_mac_o); end
      checks++; if (bus.query_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.query_err_o); end
      checks++; if (bus.hit_cnt_o !== '0 || bus.miss_cnt_o !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.hit_cnt_o, bus.miss_cnt_o); end
      checks++; if (bus.query_req_ready_o !== 1'b1 || bus.upd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", bus.query_req_ready_o, bus.upd_ready_o); end
   endtask

   task automatic test_query_miss();
      query(32'h0A000001);
      checks++; if (bus.query_resp_valid_o !== 1'b1) begin errors++; $display("FAIL miss_resp_valid: got %b expected 1", bus.query_resp_valid_o); end
      checks++; if (bus.query_err_o !== 1'b1 || bus.query_mac_o !== '0) begin errors++; $display("FAIL miss_data: got err=%b mac=%h expected err=1 mac=0", bus.query_err_o, bus.query_mac_o); end
      checks++; if (bus.miss_cnt_o !== CW'(1) || bus.hit_cnt_o !== '0) begin errors++; $display("FAIL miss_counters: got %0d/%0d expected hit 0 miss 1", bus.hit_cnt_o, bus.miss_cnt_o); end
   endtask

   task automatic test_learn();
      learn(32'h0A000001, 48'h02AABBCCDD01);
      query(32'h0A000001);
      checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== 48'h02AABBCCDD01) begin errors++; $display("FAIL learn_hit: got err=%b mac=%h expected err=0 mac=02aabbccdd01", bus.query_err_o, bus.query_mac_o); end
      checks++; if (bus.hit_cnt_o !== CW'(1)) begin errors++; $display("FAIL learn_hit_cnt: got %0d expected 1", bus.hit_cnt_o); end
      learn(32'h0A000001, 48'h02AABBCCDD02);
      query(32'h0A000001);
      checks++; if (bus.query_mac_o !== 48'h02AABBCCDD02) begin errors++; $display("FAIL relearn_mac: got %h expected 02aabbccdd02", bus.query_mac_o); end
      // Fifteen more distinct IPs must fit without evicting the re-learned one.
      for (int i = 1; i <= 15; i++) learn(32'hC0A80000 + i, mac_of(32'hC0A80000 + i));
      query(32'h0A000001);
      checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== 48'h02AABBCCDD02) begin errors++; $display("FAIL relearn_no_extra_slot: got err=%b mac=%h expected hit 02aabbccdd02", bus.query_err_o, bus.query_mac_o); end
      for (int i = 1; i <= 15; i++) begin
         query(32'hC0A80000 + i);
         checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== mac_of(32'hC0A80000 + i)) begin errors++; $display("FAIL fill_hit[%0d]: got err=%b mac=%h expected hit %h", i, bus.query_err_o, bus.query_mac_o, mac_of(32'hC0A80000 + i)); end
      end
      checks++; if (bus.hit_cnt_o !== CW'(18)) begin errors++; $display("FAIL learn_hit_total: got %0d expected 18", bus.hit_cnt_o); end
   endtask

   task automatic test_evict();
      int  ips1 [3] = '{1, 17, 2};
      bit  hit1 [3] = '{0, 1, 1};
      int  ips2 [3] = '{2, 18, 3};
      bit  hit2 [3] = '{0, 1, 1};
      do_reset();
      for (int i = 1; i <= 16; i++) learn(IW'(i), mac_of(IW'(i)));
      learn(IW'(17), mac_of(IW'(17)));
      for (int k = 0; k < 3; k++) begin
         query(IW'(ips1[k]));
         checks++; if (bus.query_err_o !== !hit1[k] || bus.query_mac_o !== (hit1[k] ? mac_of(IW'(ips1[k])) : '0)) begin errors++; $display("FAIL evict1 ip %0d: got err=%b mac=%h expected err=%b", ips1[k], bus.query_err_o, bus.query_mac_o, !hit1[k]); end
      end
      learn(IW'(18), mac_of(IW'(18)));
      for (int k = 0; k < 3; k++) begin
         query(IW'(ips2[k]));
         checks++; if (bus.query_err_o !== !hit2[k] || bus.query_mac_o !== (hit2[k] ? mac_of(IW'(ips2[k])) : '0)) begin errors++; $display("FAIL evict2 ip %0d: got err=%b mac=%h expected err=%b", ips2[k], bus.query_err_o, bus.query_mac_o, !hit2[k]); end
      end
   endtask

   task automatic test_backpressure();
      logic [MW-1:0] hold_mac;
      logic          hold_err;
      do_reset();
      learn(32'h0A0A0A0A, 48'h0211223344AA);
      step(1'b1, 32'h0A0A0A0A, 1'b0, '0, '0, 1'b0, 1'b0);
      hold_mac = bus.query_mac_o;
      hold_err = bus.query_err_o;
      checks++; if (hold_mac !== 48'h0211223344AA || hold_err !== 1'b0) begin errors++; $display("FAIL bp_first: got err=%b mac=%h expected hit 0211223344aa", hold_err, hold_mac); end
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 32'h0B0B0B0B, 1'b0, '0, '0, 1'b0, 1'b0);
         checks++; if (obs_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", k, obs_req_ready); end
         checks++; if (bus.query_resp_valid_o !== 1'b1 || bus.query_mac_o !== hold_mac || bus.query_err_o !== hold_err) begin errors++; $display("FAIL bp_stable[%0d]: got v=%b err=%b mac=%h expected v=1 err=%b mac=%h", k, bus.query_resp_valid_o, bus.query_err_o, bus.query_mac_o, hold_err, hold_mac); end
      end
      step(1'b1, 32'h0B0B0B0B, 1'b0, '0, '0, 1'b0, 1'b1);
      checks++; if (obs_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", obs_req_ready); end
      checks++; if (bus.query_resp_valid_o !== 1'b1 || bus.query_err_o !== 1'b1 || bus.query_mac_o !== '0) begin errors++; $display("FAIL bp_second_resp: got v=%b err=%b mac=%h expected v=1 err=1 mac=0", bus.query_resp_valid_o, bus.query_err_o, bus.query_mac_o); end
      checks++; if (bus.hit_cnt_o !== CW'(1) || bus.miss_cnt_o !== CW'(1)) begin errors++; $display("FAIL bp_counters: got %0d/%0d expected 1/1", bus.hit_cnt_o, bus.miss_cnt_o); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      step(1'b1, IW'(5), 1'b1, IW'(5), mac_of(IW'(5)), 1'b0, 1'b1);
      checks++; if (bus.query_err_o !== 1'b1 || bus.query_mac_o !== '0) begin errors++; $display("FAIL same_cycle_miss: got err=%b mac=%h expected miss", bus.query_err_o, bus.query_mac_o); end
      query(IW'(5));
      checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== mac_of(IW'(5))) begin errors++; $display("FAIL same_cycle_next_hit: got err=%b mac=%h expected hit %h", bus.query_err_o, bus.query_mac_o, mac_of(IW'(5))); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < N; i++) learn(32'h100 + i, mac_of(32'h100 + i));
      step(1'b1, 32'h105, 1'b1, 32'h999, mac_of(32'h999), 1'b1, 1'b1);
      checks++; if (obs_upd_ready !== 1'b0) begin errors++; $display("FAIL flush_upd_ready: got %b expected 0", obs_upd_ready); end
      checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== mac_of(32'h105)) begin errors++; $display("FAIL flush_query_preflush: got err=%b mac=%h expected hit %h", bus.query_err_o, bus.query_mac_o, mac_of(32'h105)); end
      step(1'b0, '0, 1'b1, 32'h999, mac_of(32'h999), 1'b0, 1'b1);
      checks++; if (obs_upd_ready !== 1'b1) begin errors++; $display("FAIL flush_upd_resume: got %b expected 1", obs_upd_ready); end
      for (int i = 0; i < N; i++) begin
         query(32'h100 + i);
         checks++; if (bus.query_err_o !== 1'b1) begin errors++; $display("FAIL flush_cleared[%0d]: got err=%b expected 1", i, bus.query_err_o); end
      end
      query(32'h999);
      checks++; if (bus.query_err_o !== 1'b0 || bus.query_mac_o !== mac_of(32'h999)) begin errors++; $display("FAIL flush_stalled_landed: got err=%b mac=%h expected hit", bus.query_err_o, bus.query_mac_o); end
      // With rr back at 0, the next eviction hits entry 0, which must hold the stalled learn.
      for (int i = 0; i < N - 1; i++) learn(32'h200 + i, mac_of(32'h200 + i));
      learn(32'h300, mac_of(32'h300));
      query(32'h999);
      checks++; if (bus.query_err_o !== 1'b1) begin errors++; $display("FAIL flush_entry0_evicted: got err=%b expected 1", bus.query_err_o); end
      query(32'h200);
      checks++; if (bus.query_err_o !== 1'b0) begin errors++; $display("FAIL flush_entry1_kept: got err=%b expected 0", bus.query_err_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      learn(32'h77, mac_of(32'h77));
      step(1'b1, 32'h77, 1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (bus.query_resp_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pending: got %b expected 1", bus.query_resp_valid_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.query_resp_valid_o !== 1'b0 || bus.query_mac_o !== '0 || bus.hit_cnt_o !== '0) begin errors++; $display("FAIL areset_immediate: got v=%b mac=%h hit=%0d expected 0/0/0", bus.query_resp_valid_o, bus.query_mac_o, bus.hit_cnt_o); end
      m_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      query(32'h77);
      checks++; if (bus.query_err_o !== 1'b1) begin errors++; $display("FAIL areset_table_cleared: got err=%b expected 1", bus.query_err_o); end
   endtask

   task automatic test_random();
      bit            qv, uv, fl, rdy, exp_req_ready;
      logic [IW-1:0] qip, uip;
      logic [MW-1:0] umac;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         qv   = ($urandom_range(0, 1) == 1);
         qip  = IW'($urandom_range(0, 22));
         uv   = ($urandom_range(0, 2) == 0);
         uip  = IW'($urandom_range(0, 22));
         umac = {16'($urandom), 32'($urandom)};
         fl   = ($urandom_range(0, 39) == 0);
         rdy  = ($urandom_range(0, 3) != 0);
         exp_req_ready = !m_rv || rdy;
         step(qv, qip, uv, uip, umac, fl, rdy);
         checks++; if (obs_req_ready !== exp_req_ready || obs_upd_ready !== !fl) begin errors++; $display("FAIL rnd_ready[%0d]: got %b/%b expected %b/%b", c, obs_req_ready, obs_upd_ready, exp_req_ready, !fl); end
         checks++; if (bus.query_resp_valid_o !== m_rv) begin errors++; $display("FAIL rnd_resp_valid[%0d]: got %b expected %b", c, bus.query_resp_valid_o, m_rv); end
         if (m_rv) begin
            checks++; if (bus.query_err_o !== m_rerr || bus.query_mac_o !== m_rmac) begin errors++; $display("FAIL rnd_resp_data[%0d]: got err=%b mac=%h expected err=%b mac=%h", c, bus.query_err_o, bus.query_mac_o, m_rerr, m_rmac); end
         end
         checks++; if (bus.hit_cnt_o !== CW'(m_hits) || bus.miss_cnt_o !== CW'(m_misses)) begin errors++; $display("FAIL rnd_counters[%0d]: got %0d/%0d expected %0d/%0d", c, bus.hit_cnt_o, bus.miss_cnt_o, m_hits, m_misses); end
      end
      checks++; if (bus.hit_cnt_o !== CW'(CMAX) || bus.miss_cnt_o !== CW'(CMAX)) begin errors++; $display("FAIL rnd_saturated: got %0d/%0d expected %0d/%0d", bus.hit_cnt_o, bus.miss_cnt_o, CMAX, CMAX); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_query_miss();
      test_learn();
      test_evict();
      test_backpressure();
      test_same_cycle();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/arp_table.md
Name: arp_table

Overview:
- Parametrised, fully associative IPv4-to-MAC resolution table for the load-balancer dataplane.
- Successor to the fixed single-purpose ARP lookup.
- Adds a learn/update port, replacement policy, flush and hit/miss statistics.
- Sits between the packet classifier (issues queries) and the ARP reply parser (issues updates); answers each query with a MAC or a miss error.

Parameters:
- ENTRIES, 16, number of table entries (power of two, 2..64).
- IP_W, 32, key width.
- MAC_W, 48, value width.
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- query_req_valid_i  in  1  query request valid
- query_req_ready_o  out  1  query request ready
- query_ip_i  in  IP_W  IP to resolve
- query_resp_valid_o  out  1  response valid
- query_resp_ready_i  in  1  response ready
- query_mac_o  out  MAC_W  resolved MAC (0 on miss)
- query_err_o  out  1  1 = miss
- upd_valid_i  in  1  learn request valid
- upd_ready_o  out  1  learn request ready
- upd_ip_i  in  IP_W  learned IP
- upd_mac_i  in  MAC_W  learned MAC
- flush_i  in  1  single-cycle pulse, invalidate all entries
- hit_cnt_o  out  CNT_W  query hits
- miss_cnt_o  out  CNT_W  query misses

Behaviour:
- Reset (async assert, sync release to clk):
  - All entry valid bits = 0; round-robin pointer rr = 0.
  - query_resp_valid_o = 0, query_mac_o = 0, query_err_o = 0.
  - hit_cnt_o = miss_cnt_o = 0.
  - Reset mid-transaction discards any pending response.
- Storage: ENTRIES × {valid, ip[IP_W], mac[MAC_W]} in registers; all entries compared in parallel.
- Query path: one-stage registered output.
  - query_req_ready_o = !query_resp_valid_o | query_resp_ready_i (combinational; full throughput, back-to-back queries).
  - Accept: the cycle after acceptance, query_resp_valid_o = 1.
    - Hit (any valid entry with ip == query_ip_i): query_mac_o = MAC of the lowest-index match, query_err_o = 0.
    - Miss: query_mac_o = 0, query_err_o = 1.
  - Latency is exactly 1 cycle.
  - Response data is held stable while query_resp_valid_o = 1 and query_resp_ready_i = 0.
  - query_ip_i == 0 always misses.
- Update path:
  - upd_ready_o = !flush_i.
  - On accept with upd_ip_i == 0: request consumed, no state change.
  - Else, if a valid entry matches upd_ip_i: overwrite its MAC in place; rr unchanged.
  - Else, if an invalid entry exists: write the lowest-index invalid entry, set valid; rr unchanged.
  - Else (table full): write entry rr, then rr = (rr + 1) mod ENTRIES.
  - Written contents are visible to queries accepted from the next cycle on.
- Simultaneous events:
  - Query and update accepted in the same cycle: the query sees pre-update contents.
  - Flush and query in the same cycle: the query sees pre-flush contents.
  - Flush pulse: all valid bits = 0 next cycle, rr = 0; any update presented that cycle is stalled (not dropped).
  - Flush does not affect the counters or a pending response.
- Counters: on each accepted query, hit_cnt_o or miss_cnt_o increments by 1 in the cycle the response becomes valid; both saturate at 2^CNT_W − 1 with no wrap.
- Address arithmetic: rr is $clog2(ENTRIES) bits and wraps naturally.
- No combinational path from query_ip_i or upd_* to any output.

Test Plan:
- After reset, query 10.0.0.1 (0x0A000001) -> 1 cycle later resp_valid=1, err=1, mac=0; miss_cnt=1.
- Update 0x0A000001 -> 0x02AABBCCDD01, then query 0x0A000001 -> err=0, mac=0x02AABBCCDD01; hit_cnt=1. Re-update the same IP with 0x02AABBCCDD02 -> query returns ...02 and no other entry is consumed.
- Fill all 16 entries (IPs 1..16), then update IP 17 -> entry 0 evicted: query IP 1 misses, IP 17 hits, IP 2 hits. Update IP 18 -> IP 2 evicted.
- Hold query_resp_ready_i=0 for 5 cycles with a response pending -> req_ready=0, mac/err stable; release -> next query accepted the same cycle as the handshake.
- In the same cycle: update IP 5 and query IP 5 on an empty table -> miss; query next cycle -> hit.
- Flush with a full table while upd_valid_i=1 -> upd_ready_o=0 that cycle; all prior IPs then miss; the stalled update lands in entry 0. Assert rst mid-response -> resp_valid drops to 0 immediately (async).
